// File: rtl/serializer_arbiter.sv
// Round-robin arbiter feeding one shared serializer from NUM_REQ requesters.
// Optional offer timeout: define SER_ARB_TIMEOUT_EN.
module serializer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         ser_data_o,
  output logic                          ser_valid_o,
  input  logic                          ser_ready_i,
  output logic [ID_W-1:0]               grant_id_o,
  output logic                          busy_o,
  output logic [15:0]                   tx_count_o,
  output logic                          timeout_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       pos;
  logic                  found;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  xfer;
  logic                  expire;

  // search begins one past the last grant and wraps
  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid_i[pos]) begin
        found  = 1'b1;
        winner = pos;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_W'(k)) begin
        win_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer = (state == OFFER) && ser_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (found) state_nxt = OFFER;
      end
      OFFER: begin
        if (xfer || expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    ser_valid_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && rst_n_i) req_ready_o[winner] = 1'b1;
      end
      OFFER: begin
        ser_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ser_data_o <= '0;
      grant_id_o <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      tx_count_o <= '0;
    end else begin
      if (state == IDLE && found) begin
        ser_data_o <= win_data;
        grant_id_o <= winner;
        last_grant <= winner;
      end
      if (xfer) tx_count_o <= tx_count_o + 16'd1;
    end
  end

`ifdef SER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  // a transfer on the last allowed cycle beats the drop
  assign expire = (state == OFFER) && !ser_ready_i &&
                  (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (!ser_ready_i) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/serializer_arbiter.md
# serializer_arbiter

Round-robin arbiter sharing one `serializer` instance among `NUM_REQ` requesters. Each requester offers a `DATA_WIDTH`-bit word over a valid/ready handshake. The arbiter captures one winning word into a holding register and presents it on the serializer's `valid_in_i`/`ready_o` handshake. It sits directly upstream of `serializer`, with `ser_data_o`/`ser_valid_o`/`ser_ready_i` wired to `parallel_in_i`/`valid_in_i`/`ready_o`.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: word width; must match the serializer.
- `TIMEOUT_CYCLES`, 64: offer timeout, ≥2. Used only with `SER_ARB_TIMEOUT_EN`.
- `ID_W`: local, `$clog2(NUM_REQ)`.

Ports:
- `clk_i`  in  1  clock. One clock domain; reset is asynchronous and active-low.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `req_data_i`  in  `NUM_REQ*DATA_WIDTH`  requester words; requester k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `req_valid_i`  in  `NUM_REQ`  per-requester valid.
- `req_ready_o`  out  `NUM_REQ`  per-requester ready; at most one bit high (one-hot or zero).
- `ser_data_o`  out  `DATA_WIDTH`  held word to the serializer.
- `ser_valid_o`  out  1  held word valid.
- `ser_ready_i`  in  1  serializer ready.
- `grant_id_o`  out  `ID_W`  index of the requester whose word is held or was last granted.
- `busy_o`  out  1  high while in OFFER.
- `tx_count_o`  out  16  count of completed transfers; wraps 0xFFFF→0.
- `timeout_o`  out  1  one-cycle pulse when an offer is dropped.

## Operation
- FSM states: IDLE and OFFER.
- IDLE:
  - If any `req_valid_i` bit is high, pick the winner by round-robin search starting at `last_grant+1`, wrapping modulo `NUM_REQ`.
  - `req_ready_o[winner]` is driven combinationally high in the same cycle; all other bits stay 0.
  - At the clock edge: capture the winner's word into `ser_data_o`, set `grant_id_o` and `last_grant` to the winner, go to OFFER.
- OFFER:
  - `ser_valid_o=1`, `busy_o=1`, all `req_ready_o=0`.
  - Transfer happens on an edge where `ser_valid_o && ser_ready_i`. At that edge: increment `tx_count_o`, go to IDLE.
  - `ser_data_o` is held stable until the transfer completes.
- A requester deasserting valid while not granted is legal and causes no effect.
- `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- All counters are unsigned; `tx_count_o` wraps silently.
- Reset values, including assertion mid-operation:
  - `ser_valid_o=0`, `ser_data_o=0`, `grant_id_o=0`, `busy_o=0`, `tx_count_o=0`, `timeout_o=0`.
  - `req_ready_o=0`; forced to 0 while `rst_n_i` is low.
  - State returns to IDLE and any held word is discarded.

## Timing
- Request accepted at edge T (`req_valid_i[k] && req_ready_o[k]`) → `ser_valid_o` high from T+1.
- Transfer at edge U → `ser_valid_o` low from U+1. The next acceptance can occur at U+1 at the earliest, so there are at least 2 cycles per word.
- `req_ready_o` depends combinationally on `req_valid_i` and state only, never on `ser_ready_i`.
- `ser_valid_o` is registered and does not depend combinationally on `ser_ready_i`.
- With all requesters continuously valid, grants go 0,1,2,3,0,…

## Configuration
- Macro: `SER_ARB_TIMEOUT_EN`.
- Defined:
  - A wait counter clears on entering OFFER and increments each OFFER cycle without a transfer.
  - If no transfer has occurred by the edge ending the `TIMEOUT_CYCLES`-th OFFER cycle, the word is dropped, the FSM goes to IDLE, `tx_count_o` is unchanged, and `timeout_o` is high for exactly the next cycle.
  - So `ser_valid_o` is high for at most `TIMEOUT_CYCLES` cycles.
  - If a transfer occurs on that final cycle, the transfer wins and there is no timeout.
- Undefined:
  - OFFER waits indefinitely.
  - No wait counter exists; `timeout_o` is tied 0.

## Test plan
- Reset, then all `req_valid_i=0` for 10 cycles → all outputs 0 and `req_ready_o=0000`.
- `req_valid_i=0101` with words 0xA5 (req 0) and 0x3C (req 2), `ser_ready_i=1` → `ser_data_o`=0xA5 with `grant_id_o`=0, then 0x3C with `grant_id_o`=2; `tx_count_o`=2.
- `req_valid_i=1111` held for 8 transfers → grant order 0,1,2,3,0,1,2,3; `req_ready_o` is one-hot each IDLE cycle.
- `ser_ready_i=0` for 5 cycles during OFFER → `ser_data_o` stable, `busy_o=1`, `req_ready_o=0`; transfer lands on the edge where ready rises.
- With `SER_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, `ser_ready_i=0` → `ser_valid_o` high exactly 4 cycles, one `timeout_o` pulse, `tx_count_o` unchanged, next request granted. Without the macro, `ser_valid_o` stays high for 100 cycles.
- Assert `rst_n_i=0` asynchronously mid-OFFER → outputs clear immediately without a clock edge; after release, requester 0 wins first.
